// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults, FSM state encoding and FIFO entry layout for the camera line packer.
package cam_pkg;
  localparam int BYTES_PER_LINE_DEF  = 1280;
  localparam int LINES_PER_FRAME_DEF = 480;
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    GAP  = 2'd1,
    LINE = 2'd2
  } state_t;
  localparam int ENTRY_W = 20;
  localparam int SOF_BIT = 16;
  localparam int SOL_BIT = 17;
  localparam int EOL_BIT = 18;
  localparam int EOF_BIT = 19;
endpackage

// File: rtl/cam_word_fifo.sv
// cam_word_fifo: synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
// Ports: clk, reset (async active-low), push/din write side, pop/dout read side (dout = head entry),
// full/empty status.
module cam_word_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic wen, ren;
  always_comb begin
    full  = cnt == (AW+1)'(DEPTH);
    empty = cnt == '0;
    ren   = pop && !empty;
    wen   = push && (!full || ren);
    dout  = mem[rd];
  end
  always_ff @(posedge clk) begin
    if (wen) mem[wr] <= din;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (wen) wr <= wr + AW'(1);
      if (ren) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(wen) - (AW+1)'(ren);
    end
  end
endmodule

// File: rtl/cam_line_packer.sv
// cam_line_packer: aligns camera bytes to frames, pairs them into tagged RGB565 words and queues them.
// Ports: clk, reset (async active-low); cam_data/cam_valid/cam_frame_done camera input;
// pix_data/pix_valid/pix_ready plus pix_sof/sol/eol/eof word output; line_idx, frame_cnt status;
// err_clear and sticky err_line_len/err_frame_len/err_overflow.
module cam_line_packer
  import cam_pkg::*;
#(
  parameter int BYTES_PER_LINE  = BYTES_PER_LINE_DEF,
  parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cam_data,
  input  logic        cam_valid,
  input  logic        cam_frame_done,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [9:0]  line_idx,
  output logic [15:0] frame_cnt,
  input  logic        err_clear,
  output logic        err_line_len,
  output logic        err_frame_len,
  output logic        err_overflow
);
  localparam logic [10:0] BPL       = 11'(BYTES_PER_LINE);
  localparam logic [9:0]  LAST_LINE = 10'(LINES_PER_FRAME - 1);
  state_t state, state_next;
  logic [10:0] bcnt;
  logic [7:0] held;
  logic pop, full, empty, last_line, in_range, take_byte, line_end, frame_err, word_done, len_err, overflow;
  logic [ENTRY_W-1:0] entry, head, last_word, out_word;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (cam_frame_done) state_next = GAP;
    else if (state == GAP && cam_valid) state_next = LINE;
    else if (state == LINE && !cam_valid) state_next = last_line ? SYNC : GAP;
  end
  // frame_done overrides any byte in the same cycle, so bytes are only taken without it
  always_comb begin
    pop       = !empty && pix_ready;
    last_line = line_idx == LAST_LINE;
    in_range  = bcnt < BPL;
    take_byte = !cam_frame_done && cam_valid && state != SYNC;
    line_end  = !cam_frame_done && !cam_valid && state == LINE;
    frame_err = cam_frame_done && state != SYNC;
    word_done = take_byte && in_range && bcnt[0];
    len_err   = (take_byte && !in_range) || (line_end && bcnt != BPL);
    overflow  = word_done && full && !pop;
    entry     = {bcnt == BPL - 11'd1 && last_line, bcnt == BPL - 11'd1,
                 bcnt == 11'd1, bcnt == 11'd1 && line_idx == '0, held, cam_data};
    out_word  = empty ? last_word : head;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt          <= '0;
      held          <= '0;
      line_idx      <= '0;
      frame_cnt     <= '0;
      last_word     <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      bcnt <= take_byte ? (bcnt == 11'h7FF ? bcnt : bcnt + 11'd1) : '0;
      if (take_byte && !bcnt[0]) held <= cam_data;
      if (cam_frame_done) line_idx <= '0;
      else if (line_end) line_idx <= line_idx + 10'd1;
      if (line_end && last_line) frame_cnt <= frame_cnt + 16'd1;
      // keeps the head visible after the FIFO drains
      if (!empty) last_word <= head;
      err_line_len  <= len_err || (err_line_len && !err_clear);
      err_frame_len <= frame_err || (err_frame_len && !err_clear);
      err_overflow  <= overflow || (err_overflow && !err_clear);
    end
  end
  cam_word_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(word_done), .din(entry),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  assign pix_valid = !empty;
  assign pix_data  = out_word[15:0];
  assign pix_sof   = out_word[SOF_BIT];
  assign pix_sol   = out_word[SOL_BIT];
  assign pix_eol   = out_word[EOL_BIT];
  assign pix_eof   = out_word[EOF_BIT];
endmodule
